// File: rtl/asrv32_monitor_pkg.sv
// ---------------------------------------------------------------------------
// asrv32_monitor_pkg
// Shared definitions for the asrv32 run-control / trace monitor:
//   - verdict encodings reported on o_status
//   - trace event type encodings
//   - SYSTEM instruction encodings that end a test program
//   - trace entry layout stored in the trace FIFO
//   - monitor FSM state type
//   - verdict helper implementing the riscv-tests exit convention
// ---------------------------------------------------------------------------
package asrv32_monitor_pkg;

  localparam logic [2:0] STATUS_RUNNING = 3'd0;
  localparam logic [2:0] STATUS_PASS    = 3'd1;
  localparam logic [2:0] STATUS_FAIL    = 3'd2;
  localparam logic [2:0] STATUS_UNKNOWN = 3'd3;
  localparam logic [2:0] STATUS_TIMEOUT = 3'd4;

  localparam logic TRACE_REG = 1'b0;
  localparam logic TRACE_MEM = 1'b1;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef struct packed {
    logic        ttype;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mon_state_t;

  // A program only counts as a riscv-tests exit when the magic value is
  // present; the result register then separates pass from fail.
  function automatic logic [2:0] exit_verdict(input logic [31:0] exit_val,
                                              input logic [31:0] result_val,
                                              input logic [31:0] magic);
    logic [2:0] verdict;
    verdict = STATUS_UNKNOWN;
    if (exit_val == magic) begin
      verdict = (result_val == 32'd0) ? STATUS_PASS : STATUS_FAIL;
    end
    return verdict;
  endfunction

endpackage

// File: rtl/asrv32_trace_fifo.sv
// ---------------------------------------------------------------------------
// asrv32_trace_fifo
// Dual-push, single-pop first-word-fall-through FIFO for trace entries.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_a / entry_a    first push of the cycle (written at the write pointer)
//   push_b / entry_b    second push (written after entry_a when both push)
//   pop                 remove the head entry (ignored when empty)
//   head                current head entry, valid while empty == 0
//   empty               no entries stored
//   free_slots          free entries before this cycle's pushes and pop
// The caller must never request more pushes than free_slots allows.
// ---------------------------------------------------------------------------
module asrv32_trace_fifo
  import asrv32_monitor_pkg::*;
#(
  parameter int TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_a,
  input  trace_entry_t                   entry_a,
  input  logic                           push_b,
  input  trace_entry_t                   entry_b,
  input  logic                           pop,
  output trace_entry_t                   head,
  output logic                           empty,
  output logic [$clog2(TRACE_DEPTH):0]   free_slots
);

  localparam int AW = $clog2(TRACE_DEPTH);

  trace_entry_t  mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    n_push;
  logic          do_pop;

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign do_pop = pop && (count != '0);

  // Entry storage; entry_b lands one slot after entry_a when both are pushed.
  always_ff @(posedge clk) begin
    if (push_a) begin
      mem[wr_ptr] <= entry_a;
    end
    if (push_b) begin
      mem[push_a ? wr_ptr + AW'(1) : wr_ptr] <= entry_b;
    end
  end

  // Pointers wrap naturally at TRACE_DEPTH (a power of two); the occupancy
  // counter is one bit wider so a full FIFO is distinguishable from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(n_push) - (AW+1)'(do_pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign free_slots = (AW+1)'(TRACE_DEPTH) - count;

endmodule

// File: rtl/asrv32_test_monitor.sv
// ---------------------------------------------------------------------------
// asrv32_test_monitor
// Run-control and trace monitor beside the asrv32 core. Snoops register
// writes, data-memory writes and the fetch stream; queues write events in a
// trace FIFO, detects program end, evaluates the riscv-tests exit convention
// and reports a sticky verdict.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_iaddr, i_inst, i_inst_valid  fetch stream
//   i_rd_we/addr/data              base-register write port
//   i_mem_we/addr/data/mask        data-memory write port
//   o_trace_valid/type/addr/data/mask, i_trace_ready   trace FIFO head / pop
//   o_drop_count                   events lost to a full FIFO (saturating)
//   o_cycle_count                  RUN cycles elapsed (saturating)
//   o_status                       0 RUNNING, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT
//   o_exit_code                    result register >> 1, latched at halt
//   o_done                         verdict final and trace drained
// ---------------------------------------------------------------------------
module asrv32_test_monitor
  import asrv32_monitor_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH   = 8192,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned EXIT_REG       = 17,
  parameter logic [31:0] EXIT_MAGIC     = 32'h5d,
  parameter int unsigned RESULT_REG     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_iaddr,
  input  logic [31:0] i_inst,
  input  logic        i_inst_valid,
  input  logic        i_rd_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [3:0]  i_mem_mask,
  output logic        o_trace_valid,
  output logic        o_trace_type,
  output logic [31:0] o_trace_addr,
  output logic [31:0] o_trace_data,
  output logic [3:0]  o_trace_mask,
  input  logic        i_trace_ready,
  output logic [15:0] o_drop_count,
  output logic [31:0] o_cycle_count,
  output logic [2:0]  o_status,
  output logic [30:0] o_exit_code,
  output logic        o_done
);

  localparam int   AW         = $clog2(TRACE_DEPTH);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  mon_state_t   state, state_nx;
  logic         running;
  logic         mem_ev, reg_ev;
  logic         push_mem, push_reg;
  logic [1:0]   n_drop;
  logic [AW:0]  free_slots;
  logic         fifo_empty;
  trace_entry_t mem_entry, reg_entry, head;
  logic [31:0]  exit_shadow, result_shadow;
  logic [31:0]  exit_eff, result_eff;
  logic         timeout_hit, halt;
  logic [16:0]  drop_sum;

  assign running = (state == ST_RUN);
  assign mem_ev  = running && i_mem_we;
  assign reg_ev  = running && i_rd_we && (i_rd_addr != 5'd0);

  assign mem_entry = '{ttype: TRACE_MEM, addr: i_mem_addr, data: i_mem_data, mask: i_mem_mask};
  assign reg_entry = '{ttype: TRACE_REG, addr: {27'd0, i_rd_addr}, data: i_rd_data, mask: 4'b1111};

  // Memory event has first claim on free slots; anything that does not fit
  // is counted as dropped. Free space excludes this cycle's pop.
  always_comb begin
    push_mem = 1'b0;
    push_reg = 1'b0;
    n_drop   = 2'd0;
    if (mem_ev) begin
      if (free_slots != '0) push_mem = 1'b1;
      else                  n_drop   = n_drop + 2'd1;
    end
    if (reg_ev) begin
      if (free_slots > (AW+1)'(push_mem)) push_reg = 1'b1;
      else                                n_drop   = n_drop + 2'd1;
    end
  end

  // Bypass so a register write in the halt cycle takes part in the verdict.
  assign exit_eff   = (reg_ev && i_rd_addr == 5'(EXIT_REG))   ? i_rd_data : exit_shadow;
  assign result_eff = (reg_ev && i_rd_addr == 5'(RESULT_REG)) ? i_rd_data : result_shadow;

  assign timeout_hit = TIMEOUT_EN && (({1'b0, o_cycle_count} + 33'd1) == 33'(TIMEOUT_CYCLES));
  assign halt = running &&
                ((i_inst_valid && (i_inst == INST_EBREAK || i_inst == INST_ECALL)) ||
                 (i_iaddr >= 32'(MEMORY_DEPTH - 4)) ||
                 timeout_hit);

  asrv32_trace_fifo #(.TRACE_DEPTH(TRACE_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_a     (push_mem),
    .entry_a    (mem_entry),
    .push_b     (push_reg),
    .entry_b    (reg_entry),
    .pop        (i_trace_ready),
    .head       (head),
    .empty      (fifo_empty),
    .free_slots (free_slots)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  // FSM next state: halt ends the run, then wait for the trace to drain.
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (halt)       state_nx = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  assign drop_sum = {1'b0, o_drop_count} + 17'(n_drop);

  // Counters, shadows and the verdict; the verdict is written only on the
  // halt edge and then holds until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cycle_count <= '0;
      o_drop_count  <= '0;
      exit_shadow   <= '0;
      result_shadow <= '0;
      o_status      <= STATUS_RUNNING;
      o_exit_code   <= '0;
    end else begin
      o_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (running) begin
        if (o_cycle_count != 32'hFFFF_FFFF) o_cycle_count <= o_cycle_count + 32'd1;
        exit_shadow   <= exit_eff;
        result_shadow <= result_eff;
        if (halt) begin
          o_status    <= timeout_hit ? STATUS_TIMEOUT
                                     : exit_verdict(exit_eff, result_eff, EXIT_MAGIC);
          o_exit_code <= result_eff[31:1];
        end
      end
    end
  end

  // Head fields are forced to zero while nothing is queued so stale storage
  // never leaks onto the outputs.
  assign o_trace_valid = !fifo_empty;
  assign o_trace_type  = o_trace_valid ? head.ttype : 1'b0;
  assign o_trace_addr  = o_trace_valid ? head.addr  : 32'd0;
  assign o_trace_data  = o_trace_valid ? head.data  : 32'd0;
  assign o_trace_mask  = o_trace_valid ? head.mask  : 4'd0;
  assign o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_asrv32_test_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_asrv32_test_monitor
// Scoreboard bench: each driven cycle runs a behavioural model of the monitor
// that queues the expected trace entries; a separate monitor process pops and
// compares whenever the DUT's trace head is consumed.
// ---------------------------------------------------------------------------
module tb_asrv32_test_monitor;

  localparam int MEM_DEPTH = 8192;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_iaddr = '0, i_inst = '0, i_rd_data = '0, i_mem_addr = '0, i_mem_data = '0;
  logic        i_inst_valid = 1'b0, i_rd_we = 1'b0, i_mem_we = 1'b0, i_trace_ready = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [3:0]  i_mem_mask = '0;
  logic        o_trace_valid, o_trace_type, o_done;
  logic [31:0] o_trace_addr, o_trace_data, o_cycle_count;
  logic [3:0]  o_trace_mask;
  logic [15:0] o_drop_count;
  logic [2:0]  o_status;
  logic [30:0] o_exit_code;

  always #5 clk = ~clk;

  asrv32_test_monitor #(
    .MEMORY_DEPTH(MEM_DEPTH), .TRACE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT),
    .EXIT_REG(17), .EXIT_MAGIC(32'h5d), .RESULT_REG(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_iaddr(i_iaddr), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .i_rd_we(i_rd_we), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_mask(i_mem_mask),
    .o_trace_valid(o_trace_valid), .o_trace_type(o_trace_type), .o_trace_addr(o_trace_addr),
    .o_trace_data(o_trace_data), .o_trace_mask(o_trace_mask), .i_trace_ready(i_trace_ready),
    .o_drop_count(o_drop_count), .o_cycle_count(o_cycle_count), .o_status(o_status),
    .o_exit_code(o_exit_code), .o_done(o_done)
  );

  typedef struct {
    bit        ttype;
    bit [31:0] addr;
    bit [31:0] data;
    bit [3:0]  mask;
  } exp_entry_t;

  exp_entry_t expQ[$];
  int nCompared = 0;
  int nMismatched = 0;
  int headCount = 0;

  // Reference model: phase 0 running, 1 halted and draining, 2 finished.
  int          mPhase;
  bit [31:0]   mRegs[32];
  longint      mCycles;
  int          mDrops;
  bit [2:0]    mStatus;
  bit [30:0]   mExit;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    headCount = 0;
    mPhase = 0;
    for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
    mCycles = 0;
    mDrops = 0;
    mStatus = 3'd0;
    mExit = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now driven.
  task automatic modelStep();
    int  room;
    bit  timeoutNow, endInst;
    if (mPhase == 0) begin
      room = DEPTH - expQ.size();
      if (i_mem_we) begin
        if (room > 0) begin
          expQ.push_back('{1'b1, i_mem_addr, i_mem_data, i_mem_mask});
          room--;
        end else mDrops++;
      end
      if (i_rd_we && i_rd_addr != 0) begin
        if (room > 0) expQ.push_back('{1'b0, {27'd0, i_rd_addr}, i_rd_data, 4'hF});
        else mDrops++;
        mRegs[i_rd_addr] = i_rd_data;
      end
      if (mDrops > 65535) mDrops = 65535;
      timeoutNow = (mCycles + 1 == TIMEOUT);
      mCycles++;
      endInst = i_inst_valid && (i_inst == 32'h00100073 || i_inst == 32'h00000073);
      if (endInst || i_iaddr >= MEM_DEPTH - 4 || timeoutNow) begin
        if (timeoutNow)                 mStatus = 3'd4;
        else if (mRegs[17] == 32'h5d)   mStatus = (mRegs[10] == 0) ? 3'd1 : 3'd2;
        else                            mStatus = 3'd3;
        mExit = mRegs[10] >> 1;
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (expQ.size() == 0) mPhase = 2;
    end
  endtask

  task automatic checkOutput();
    cmp("status", o_status, mStatus);
    cmp("done", o_done, mPhase == 2);
    cmp("cycle_count", o_cycle_count, mCycles);
    cmp("drop_count", o_drop_count, mDrops);
    cmp("exit_code", o_exit_code, mExit);
  endtask

  task automatic applyStimulus(input bit memWe, input bit [31:0] memAddr, input bit [31:0] memData,
                               input bit [3:0] memMask, input bit rdWe, input bit [4:0] rdAddr,
                               input bit [31:0] rdData, input bit instValid, input bit [31:0] inst,
                               input bit [31:0] iaddr, input bit ready);
    @(negedge clk); #1;
    checkOutput();
    i_mem_we = memWe; i_mem_addr = memAddr; i_mem_data = memData; i_mem_mask = memMask;
    i_rd_we = rdWe; i_rd_addr = rdAddr; i_rd_data = rdData;
    i_inst_valid = instValid; i_inst = inst; i_iaddr = iaddr; i_trace_ready = ready;
    headCount = expQ.size();
    modelStep();
  endtask

  task automatic idle(input bit ready);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h00000013, 32'h100, ready);
  endtask

  task automatic regWrite(input bit [4:0] a, input bit [31:0] d, input bit ready);
    applyStimulus(0, 0, 0, 0, 1, a, d, 1'b1, 32'h00000013, 32'h100, ready);
  endtask

  task automatic haltInst(input bit [31:0] inst, input bit ready);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, inst, 32'h104, ready);
  endtask

  task automatic runUntilDone(input int maxCycles);
    for (int i = 0; i < maxCycles && mPhase != 2; i++) idle(1);
    idle(1);
  endtask

  // Reset is asserted between clock edges to exercise its asynchronous path.
  task automatic applyReset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    i_mem_we = 0; i_rd_we = 0; i_inst_valid = 0; i_trace_ready = 0;
    i_iaddr = 32'h100; i_inst = 0; i_rd_addr = 0; i_rd_data = 0;
    i_mem_addr = 0; i_mem_data = 0; i_mem_mask = 0;
    #1;
    cmp("rst_status", o_status, 0);
    cmp("rst_done", o_done, 0);
    cmp("rst_cycles", o_cycle_count, 0);
    cmp("rst_drops", o_drop_count, 0);
    cmp("rst_exit", o_exit_code, 0);
    cmp("rst_trace", {o_trace_valid, o_trace_type, o_trace_addr, o_trace_data, o_trace_mask}, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    modelStep();
  endtask

  // Scoreboard monitor: samples just before each rising edge.
  initial begin
    exp_entry_t e;
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        cmp("trace_valid", o_trace_valid, headCount > 0);
        if (o_trace_valid && i_trace_ready) begin
          if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL trace_extra: got entry addr 0x%0h required none", o_trace_addr);
          end else begin
            e = expQ.pop_front();
            cmp("trace_type", o_trace_type, e.ttype);
            cmp("trace_addr", o_trace_addr, e.addr);
            cmp("trace_data", o_trace_data, e.data);
            cmp("trace_mask", o_trace_mask, e.mask);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [31:0] r, inst, iaddr, rdData;
    bit [4:0]  rdAddr;

    // Pass: three queued events, ebreak, drain in order.
    applyReset();
    regWrite(17, 32'h5d, 0);
    regWrite(10, 32'h0, 0);
    applyStimulus(1, 32'h200, 32'hdeadbeef, 4'b0011, 0, 0, 0, 1'b1, 32'h13, 32'h100, 0);
    haltInst(32'h00100073, 0);
    runUntilDone(20);
    cmp("A_status", o_status, 1);
    cmp("A_exit", o_exit_code, 0);
    cmp("A_done", o_done, 1);

    // Fail code via ecall.
    applyReset();
    regWrite(17, 32'h5d, 1);
    regWrite(10, 32'h6, 1);
    haltInst(32'h00000073, 1);
    runUntilDone(20);
    cmp("B_status", o_status, 2);
    cmp("B_exit", o_exit_code, 3);

    // Fetch runs off the end of memory.
    applyReset();
    for (int pc = 8160; pc < 8188; pc += 4)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h13, pc, 1);
    cmp("C_not_done", o_status, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h13, 32'd8188, 1);
    runUntilDone(20);
    cmp("C_status", o_status, 3);
    cmp("C_done", o_done, 1);

    // Timeout with no halt.
    applyReset();
    for (int i = 0; i < 60; i++) idle(1);
    cmp("D_status", o_status, 4);
    cmp("D_cycles", o_cycle_count, 50);

    // Overflow of a 4-deep FIFO with ready held low.
    applyReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h300 + 4*i, 32'h1000 + i, 4'b1111, 1, 5 + i, 32'h2000 + i,
                    1'b1, 32'h13, 32'h100, 0);
    idle(0);
    cmp("E_drops", o_drop_count, 2);
    cmp("E_valid", o_trace_valid, 1);
    haltInst(32'h00100073, 1);
    runUntilDone(20);
    cmp("E_done", o_done, 1);

    // x0 writes are invisible; reset during DRAIN clears everything.
    applyReset();
    regWrite(10, 32'h8, 0);
    regWrite(0, 32'hFFFFFFFF, 0);
    haltInst(32'h00100073, 0);
    idle(0);
    idle(0);
    cmp("F_draining", o_done, 0);
    cmp("F_status", o_status, 3);
    cmp("F_exit", o_exit_code, 4);
    applyReset();
    for (int i = 0; i < 3; i++) idle(1);
    cmp("F_run_again", o_cycle_count, 3);

    // Randomized runs against the model.
    for (int run = 0; run < 25; run++) begin
      applyReset();
      for (int c = 0; c < 70 && mPhase == 0; c++) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0: rdAddr = 0;
          1: rdAddr = 10;
          2: rdAddr = 17;
          default: rdAddr = 5'($urandom);
        endcase
        rdData = (r[3:2] == 0) ? 32'h5d : (r[3:2] == 1) ? 32'h0 : $urandom;
        case ($urandom_range(0, 31))
          0: inst = 32'h00100073;
          1: inst = 32'h00000073;
          default: inst = $urandom & 32'hFFFFFF00;
        endcase
        case ($urandom_range(0, 39))
          0: iaddr = 32'd8188 + $urandom_range(0, 100);
          1: iaddr = 32'd8187;
          default: iaddr = $urandom_range(0, 8187);
        endcase
        applyStimulus(r[4], $urandom, $urandom, 4'($urandom), r[5], rdAddr, rdData,
                      r[6], inst, iaddr, r[7] | r[8]);
      end
      runUntilDone(40);
      cmp("R_done", o_done, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/asrv32_test_monitor.md
Name: asrv32_test_monitor

Overview:
Synthesisable run-control and trace monitor that sits beside the asrv32 core inside the SoC. It snoops the base-register write port, the data-memory write port and the fetch stream. It buffers those events in a parametrised trace FIFO, detects program end and evaluates the riscv-tests exit convention (x17 == 0x5d, x10 == 0). It adds a cycle timeout and reports a sticky verdict that both the benches and FPGA builds can read.

Parameters:
MEMORY_DEPTH, 8192, memory size in bytes; a fetch address >= MEMORY_DEPTH-4 ends the run.
TRACE_DEPTH, 16, trace FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 100000, RUN cycles before a TIMEOUT verdict; 0 disables the timeout.
EXIT_REG, 17, index of the register holding the exit magic.
EXIT_MAGIC, 32'h5d, value in EXIT_REG that marks a riscv-tests exit.
RESULT_REG, 10, index of the register holding the result code.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_iaddr  in  32  current fetch address
i_inst  in  32  current instruction word
i_inst_valid  in  1  i_inst is valid this cycle
i_rd_we  in  1  base-register write strobe
i_rd_addr  in  5  base-register write index
i_rd_data  in  32  base-register write data
i_mem_we  in  1  data-memory write strobe
i_mem_addr  in  32  data-memory write address
i_mem_data  in  32  data-memory write data
i_mem_mask  in  4  data-memory byte mask
o_trace_valid  out  1  trace head valid
o_trace_type  out  1  0 = register write, 1 = memory write
o_trace_addr  out  32  register index (zero-extended) or memory address
o_trace_data  out  32  written data
o_trace_mask  out  4  byte mask; 4'b1111 for register events
i_trace_ready  in  1  consumer pops the head
o_drop_count  out  16  events lost to a full FIFO, saturating
o_cycle_count  out  32  RUN cycles elapsed
o_status  out  3  0 RUNNING, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT
o_exit_code  out  31  shadow x10 >> 1, latched at halt
o_done  out  1  verdict final and trace drained

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0. FSM enters RUN. Shadow registers for EXIT_REG and RESULT_REG are 0. FIFO is empty. Reset mid-run discards the trace and the verdict.
- FSM states:
  - RUN: on each edge, capture events and increment o_cycle_count (saturating).
  - RUN -> DRAIN on halt, which is any of: i_inst_valid with i_inst == 32'h00100073 (ebreak); i_inst_valid with i_inst == 32'h00000073 (ecall); i_iaddr >= MEMORY_DEPTH-4; o_cycle_count+1 == TIMEOUT_CYCLES with TIMEOUT_CYCLES != 0.
  - DRAIN: no capture; the cycle counter is frozen; the verdict is already latched. DRAIN -> DONE when the FIFO is empty.
  - DONE: o_done = 1. Terminal until reset.
- Verdict, latched on the halt edge:
  - Timeout has priority and gives TIMEOUT.
  - Otherwise, if shadow EXIT_REG == EXIT_MAGIC: PASS when shadow RESULT_REG == 0, else FAIL.
  - Otherwise UNKNOWN.
  - Shadows use bypass: a register write in the halt cycle is included in the verdict.
  - o_status reads 0 until the halt edge, then holds the verdict.
- Capture (RUN only):
  - Register writes to index 0 are neither traced nor shadowed.
  - Events present in the halt cycle are captured.
- FIFO:
  - First-word-fall-through; the o_trace_* fields show the head while o_trace_valid is 1.
  - Pop when o_trace_valid && i_trace_ready.
  - Up to two pushes per cycle, memory event first, then register event.
  - Free-slot count is sampled before that cycle's pop; a same-cycle pop does not create room.
  - free >= 2: push both events.
  - free == 1: push the memory event; drop the register event; drop count +1.
  - free == 0: drop all events that cycle, adding the number dropped to the drop count.
  - Pointers wrap modulo TRACE_DEPTH. An occupancy counter (log2(TRACE_DEPTH)+1 bits) distinguishes full from empty.
  - o_drop_count saturates at 16'hFFFF.
- Latency: a captured event appears at the head no earlier than one cycle after its strobe.

Decomposition:
- Package asrv32_monitor_pkg:
  - status encoding constants;
  - trace-type constants;
  - EBREAK/ECALL encodings;
  - trace entry typedef {type, addr[31:0], data[31:0], mask[3:0]}.
- Sub-module asrv32_trace_fifo: dual-push, single-pop FWFT FIFO parametrised by TRACE_DEPTH. It reports free-slot count and empty.

Test Plan:
- Write x17 = 0x5d and x10 = 0, then ebreak -> status 1, exit_code 0, done after the trace drains (3 entries in order).
- Write x17 = 0x5d and x10 = 0x6, then ecall -> status 2, exit_code 0x3.
- No write to x17, then fetch reaches address 8188 -> status 3, done = 1.
- TIMEOUT_CYCLES = 50 with no halt -> status 4 at cycle 50, cycle_count = 50.
- TRACE_DEPTH = 4 with ready held low: 3 cycles of simultaneous memory + register writes -> 4 entries queued (mem, reg, mem, reg), drop_count = 2; releasing ready pops them in that order.
- Write to x0 with data 0xFFFFFFFF -> no trace entry and shadows unchanged; reset asserted in DRAIN -> all outputs 0 and FSM back in RUN.
